pbi_bus_capture: RTL and testbench

Parametrised capture engine for Atari expansion/cartridge bus traffic (address, data, strobes, control lines packed into one channel vector). It samples the bus on a qualifier strobe into a circular trace buffer with a mask/value trigger and programmable pre-trigger depth. It then drains the buffer oldest-first as {delta-time, channels} records for the CSV/VCD export path. It sits between the bus pin synchroniser and the host readout logic and generalises the fixed-signal bus tap to any channel count, depth and capture mode.

---
 rtl/pbi_bus_capture.sv | 192 +++++++++++++++++++
 tb/tb_pbi_bus_capture.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pbi_bus_capture.sv
// Bus-trace capture engine: samples the bus on a qualifier strobe into a circular
// buffer around a mask/value trigger, then drains {delta-time, channels} oldest-first.
module pbi_bus_capture #(
  parameter int  CH_W  = 48,
  parameter int  DEPTH = 256,
  parameter int  TS_W  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_en,
  input  logic [CH_W-1:0]      bus_in,
  input  logic [CH_W-1:0]      trig_mask,
  input  logic [CH_W-1:0]      trig_value,
  input  logic [AW-1:0]        pretrig,
  input  logic                 change_only,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [TS_W+CH_W-1:0] rd_data,
  output logic [2:0]           state,
  output logic                 triggered,
  output logic [AW-1:0]        trig_addr
);
  localparam int RW = TS_W + CH_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RD_LOAD,
    RD_FETCH,
    RD_STREAM
  } rd_phase_t;

  state_t          state_q, next_state;
  rd_phase_t       rd_phase;
  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, fill_cnt, post_cnt, pretrig_q, post_load;
  logic [AW:0]     remain;
  logic [TS_W-1:0] delta_cnt, wr_delta;
  logic [CH_W-1:0] last_bus;
  logic            change_only_q, first_rec;
  logic            capturing, arm_ok, hit, wr_en, rd_fire;

  assign state = state_q;

  assign capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign arm_ok    = arm && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign hit       = (state_q == S_WAIT) && sample_en &&
                     (((bus_in ^ trig_value) & trig_mask) == '0);
  assign wr_en     = capturing && sample_en && !abort &&
                     (!change_only_q || first_rec || (bus_in != last_bus) || hit);
  assign wr_delta  = first_rec ? '0 : delta_cnt;
  // Records still to take after the trigger so the window totals DEPTH entries.
  assign post_load = {AW{1'b1}} - pretrig_q;
  assign rd_fire   = (state_q == S_DONE) && (rd_phase == RD_STREAM) && rd_valid && rd_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state_q;
    if (abort) begin
      next_state = S_IDLE;
    end else if (arm_ok) begin
      next_state = (pretrig == '0) ? S_WAIT : S_PRE;
    end else begin
      case (state_q)
        S_IDLE: next_state = S_IDLE;
        // A write that completes the pre-trigger fill cannot also be the trigger.
        S_PRE:  if (wr_en && ((fill_cnt + AW'(1)) == pretrig_q)) next_state = S_WAIT;
        S_WAIT: if (hit) next_state = (post_load == '0) ? S_DONE : S_POST;
        S_POST: if (wr_en && (post_cnt == AW'(1))) next_state = S_DONE;
        S_DONE: if (rd_fire && (remain == (AW+1)'(1))) next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // NOTE: the trace buffer is deliberately not reset; only pointers and flags are,
  // which keeps it mappable onto LUT RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {wr_delta, bus_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill_cnt      <= '0;
      post_cnt      <= '0;
      pretrig_q     <= '0;
      remain        <= '0;
      delta_cnt     <= '0;
      last_bus      <= '0;
      change_only_q <= 1'b0;
      first_rec     <= 1'b0;
      rd_phase      <= RD_LOAD;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      triggered     <= 1'b0;
      trig_addr     <= '0;
    end else if (abort) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      remain    <= '0;
      delta_cnt <= '0;
      first_rec <= 1'b0;
      rd_phase  <= RD_LOAD;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      triggered <= 1'b0;
      trig_addr <= '0;
    end else if (arm_ok) begin
      pretrig_q     <= pretrig;
      change_only_q <= change_only;
      wr_ptr        <= '0;
      fill_cnt      <= '0;
      post_cnt      <= '0;
      remain        <= '0;
      delta_cnt     <= '0;
      first_rec     <= 1'b1;
      rd_phase      <= RD_LOAD;
      rd_valid      <= 1'b0;
      triggered     <= 1'b0;
    end else begin
      if (wr_en)                   delta_cnt <= TS_W'(1);
      else if (delta_cnt != '1)    delta_cnt <= delta_cnt + TS_W'(1);

      if (wr_en) begin
        wr_ptr    <= wr_ptr + AW'(1);
        last_bus  <= bus_in;
        first_rec <= 1'b0;
      end

      if ((state_q == S_PRE) && wr_en) fill_cnt <= fill_cnt + AW'(1);

      if (hit) begin
        triggered <= 1'b1;
        trig_addr <= wr_ptr;
        post_cnt  <= post_load;
      end else if ((state_q == S_POST) && wr_en) begin
        post_cnt <= post_cnt - AW'(1);
      end

      // Readout: load the oldest address, prefetch one record, then stream.
      // rd_ptr always addresses the next record to be fetched.
      if (state_q == S_DONE) begin
        case (rd_phase)
          RD_LOAD: begin
            rd_ptr   <= trig_addr - pretrig_q;
            rd_phase <= RD_FETCH;
          end
          RD_FETCH: begin
            rd_data  <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + AW'(1);
            rd_valid <= 1'b1;
            remain   <= (AW+1)'(DEPTH);
            rd_phase <= RD_STREAM;
          end
          default: begin
            if (rd_fire) begin
              remain <= remain - (AW+1)'(1);
              if (remain == (AW+1)'(1)) begin
                rd_valid <= 1'b0;
                rd_phase <= RD_LOAD;
              end else begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pbi_bus_capture.sv
// Directed bench for pbi_bus_capture at CH_W=8, DEPTH=16, TS_W=8: trigger windows,
// delta timing and saturation, readout handshake, abort, ignored arm and async reset.
module tb_pbi_bus_capture;
  localparam int CH_W  = 8;
  localparam int DEPTH = 16;
  localparam int TS_W  = 8;
  localparam int AW    = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 sample_en;
  logic [CH_W-1:0]      bus_in;
  logic [CH_W-1:0]      trig_mask;
  logic [CH_W-1:0]      trig_value;
  logic [AW-1:0]        pretrig;
  logic                 change_only;
  logic                 arm;
  logic                 abort;
  logic                 rd_ready;
  logic                 rd_valid;
  logic [TS_W+CH_W-1:0] rd_data;
  logic [2:0]           state;
  logic                 triggered;
  logic [AW-1:0]        trig_addr;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_rec [DEPTH];
  logic [7:0]  nv;

  pbi_bus_capture #(.CH_W(CH_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .bus_in     (bus_in),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .pretrig    (pretrig),
    .change_only(change_only),
    .arm        (arm),
    .abort      (abort),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .state      (state),
    .triggered  (triggered),
    .trig_addr  (trig_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_arm(input logic [3:0] pt, input logic co,
                        input logic [7:0] mask, input logic [7:0] val);
    pretrig     = pt;
    change_only = co;
    trig_mask   = mask;
    trig_value  = val;
    arm         = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Ramp the bus by one per sample, sampling every 'period' cycles, until 'target'.
  task automatic ramp(input logic [7:0] start, input int period,
                      input logic [2:0] target, output logic [7:0] next_v);
    logic [7:0] v;
    int         ph;
    v  = start;
    ph = 0;
    for (int c = 0; c < 2000; c++) begin
      if (state == target) break;
      bus_in    = v;
      sample_en = (ph == 0);
      @(negedge clk);
      if (ph == 0) v = v + 8'd1;
      ph = (ph + 1) % period;
    end
    sample_en = 1'b0;
    next_v    = v;
    check("reach_state", 32'(state), 32'(target));
  endtask

  task automatic fill_ramp(input logic [7:0] ch0, input logic [7:0] d0, input logic [7:0] dn);
    for (int i = 0; i < DEPTH; i++) exp_rec[i] = {(i == 0) ? d0 : dn, ch0 + 8'(i)};
  endtask

  // Entered on the first negedge with state == DONE.
  task automatic drain(input bit stall);
    int idx;
    int k;
    idx = 0;
    k   = 0;
    check("valid_lat0", 32'(rd_valid), 32'd0);
    @(negedge clk);
    check("valid_lat1", 32'(rd_valid), 32'd0);
    @(negedge clk);
    check("valid_lat2", 32'(rd_valid), 32'd1);
    while (idx < DEPTH && k < 200) begin
      rd_ready = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      if (rd_valid) begin
        check($sformatf("rec%0d", idx), 32'(rd_data), 32'(exp_rec[idx]));
        if (rd_ready) idx++;
      end
      @(negedge clk);
      k++;
    end
    rd_ready = 1'b0;
    check("drain_count", 32'(idx), 32'(DEPTH));
    check("drain_valid_low", 32'(rd_valid), 32'd0);
    check("drain_idle", 32'(state), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sample_en = 1'b0; bus_in = '0; trig_mask = '0; trig_value = '0;
    pretrig = '0; change_only = 1'b0; arm = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_trig", 32'(triggered), 32'd0);
    check("rst_taddr", 32'(trig_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp, sample every cycle, trigger at 0x20 with 4 pre-trigger records.
    do_arm(4'd4, 1'b0, 8'hFF, 8'h20);
    check("arm_pre", 32'(state), 32'd1);
    ramp(8'h00, 1, 3'd4, nv);
    check("t1_triggered", 32'(triggered), 32'd1);
    check("t1_taddr", 32'(trig_addr), 32'd0);
    fill_ramp(8'h1C, 8'd1, 8'd1);
    drain(1'b0);

    // Same window with sample_en every third cycle.
    do_arm(4'd4, 1'b0, 8'hFF, 8'h20);
    ramp(8'h00, 3, 3'd4, nv);
    check("t2_triggered", 32'(triggered), 32'd1);
    fill_ramp(8'h1C, 8'd3, 8'd3);
    drain(1'b0);

    // Change-only: long idle stretch saturates the delta.
    do_arm(4'd1, 1'b1, 8'hFF, 8'h56);
    bus_in    = 8'h55;
    sample_en = 1'b1;
    repeat (300) @(negedge clk);
    check("t3_wait", 32'(state), 32'd2);
    ramp(8'h56, 1, 3'd4, nv);
    check("t3_taddr", 32'(trig_addr), 32'd1);
    for (int i = 0; i < DEPTH; i++) exp_rec[i] = {8'd1, 8'h55 + 8'(i)};
    exp_rec[0] = 16'h0055;
    exp_rec[1] = 16'hFF56;
    drain(1'b0);

    // pretrig=0, trigger on the first sample, stalled readout 1,0,0,1.
    do_arm(4'd0, 1'b0, 8'hFF, 8'h40);
    check("t4_wait_direct", 32'(state), 32'd2);
    ramp(8'h40, 1, 3'd4, nv);
    check("t4_taddr", 32'(trig_addr), 32'd0);
    fill_ramp(8'h40, 8'd0, 8'd1);
    drain(1'b1);

    // pretrig=15: trigger is the last record, straight to DONE.
    do_arm(4'd15, 1'b0, 8'hFF, 8'h0F);
    ramp(8'h00, 1, 3'd4, nv);
    check("t5_taddr", 32'(trig_addr), 32'd15);
    fill_ramp(8'h00, 8'd0, 8'd1);
    drain(1'b0);

    // Match on the final PRE write is ignored; next match (0x13) triggers.
    do_arm(4'd4, 1'b0, 8'h0F, 8'h03);
    ramp(8'h00, 1, 3'd4, nv);
    check("t6_taddr", 32'(trig_addr), 32'd3);
    fill_ramp(8'h0F, 8'd1, 8'd1);
    drain(1'b0);

    // arm while in WAIT is ignored; capture completes with the original settings.
    do_arm(4'd2, 1'b0, 8'hFF, 8'h10);
    ramp(8'h00, 1, 3'd2, nv);
    pretrig     = 4'd6;
    change_only = 1'b1;
    arm         = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    check("t7_arm_ignored", 32'(state), 32'd2);
    ramp(nv, 1, 3'd4, nv);
    check("t7_taddr", 32'(trig_addr), 32'd0);
    fill_ramp(8'h0E, 8'd1, 8'd1);
    drain(1'b0);

    // Abort in POST together with arm: abort wins.
    do_arm(4'd4, 1'b0, 8'hFF, 8'h20);
    ramp(8'h00, 1, 3'd3, nv);
    check("t8_trig_before", 32'(triggered), 32'd1);
    abort = 1'b1;
    arm   = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    arm   = 1'b0;
    check("t8_state", 32'(state), 32'd0);
    check("t8_valid", 32'(rd_valid), 32'd0);
    check("t8_trig", 32'(triggered), 32'd0);
    @(negedge clk);
    check("t8_stay_idle", 32'(state), 32'd0);

    // Asynchronous reset in the middle of readout.
    do_arm(4'd4, 1'b0, 8'hFF, 8'h20);
    ramp(8'h00, 1, 3'd4, nv);
    repeat (2) @(negedge clk);
    check("t9_valid_up", 32'(rd_valid), 32'd1);
    check("t9_first_rec", 32'(rd_data), 32'h011C);
    #1 rst_n = 1'b0;
    #1;
    check("t9_rst_state", 32'(state), 32'd0);
    check("t9_rst_valid", 32'(rd_valid), 32'd0);
    check("t9_rst_data", 32'(rd_data), 32'd0);
    check("t9_rst_trig", 32'(triggered), 32'd0);
    check("t9_rst_taddr", 32'(trig_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
